// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART serial blocks.
//   rx_state_t  - receiver frame state
//   OS_RATIO    - fixed oversample ratio (16 samples per bit)
//   VOTE_IDX_*  - sample indices used for the mid-bit majority vote
//   baud_div()  - rounded clock divider for a given clock, baud and ratio
//   maj3()      - two-of-three majority
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned OS_RATIO   = 16;
    localparam logic [3:0]  VOTE_IDX_A = 4'd7;
    localparam logic [3:0]  VOTE_IDX_B = 4'd8;
    localparam logic [3:0]  VOTE_IDX_C = 4'd9;
    localparam logic [3:0]  SAMP_LAST  = 4'd15;

    // round(clk_hz / (baud * os))
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing one-cycle sample ticks.
//   sys_clk - clock
//   rst     - synchronous active-high reset
//   clr     - synchronous restart; first tick follows DIV cycles later
//   tick    - one-cycle pulse every DIV cycles
module uart_baud_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: DIV must be at least 2");
    end

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge sys_clk) begin
        if (rst || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    always_comb begin
        tick = (cnt_q == LAST);
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampling 8N1 receiver with majority vote,
// false-start rejection and framing-error reporting.
//   sys_clk   - clock
//   rst       - synchronous active-high reset
//   uart_rxd  - asynchronous RX pin, idle high
//   uart_data - last correctly framed byte (LSB first on the wire)
//   uart_done - one-cycle pulse, uart_data valid on and after it
//   frame_err - one-cycle pulse when the stop bit votes low
//   busy      - high whenever a frame is in progress
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OS     = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OS);

    if (OS != OS_RATIO) begin : g_bad_os
        $error("uart_rx_oversample: OS must be 16");
    end

    // Synchronizer plus previous-sample register for edge detection.
    logic rx_meta_q;
    logic rxs_q;
    logic rxs_prev_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    rx_state_t  state_q;
    logic [3:0] scnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic [2:0] samp_q;
    logic [7:0] data_q;
    logic       done_q;
    logic       ferr_q;

    logic fall_d;
    logic clr_d;
    logic tick;
    logic vote_bnd_d;
    logic vote_mid_d;

    always_comb begin
        fall_d     = rxs_prev_q & ~rxs_q;
        clr_d      = (state_q == IDLE) && fall_d;
        vote_bnd_d = maj3(samp_q[0], samp_q[1], samp_q[2]);
        // The stop decision is taken on the third vote tick itself, so the
        // live sample stands in for the not-yet-registered third vote.
        vote_mid_d = maj3(samp_q[0], samp_q[1], rxs_q);
    end

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .sys_clk(sys_clk),
        .rst    (rst),
        .clr    (clr_d),
        .tick   (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            samp_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            if (state_q == IDLE) begin
                if (fall_d) begin
                    state_q <= START;
                    scnt_q  <= '0;
                    bit_q   <= '0;
                    samp_q  <= '0;
                end
            end else if (tick) begin
                scnt_q <= scnt_q + 4'd1;
                if (scnt_q == VOTE_IDX_A) samp_q[0] <= rxs_q;
                if (scnt_q == VOTE_IDX_B) samp_q[1] <= rxs_q;
                if (scnt_q == VOTE_IDX_C) samp_q[2] <= rxs_q;

                if (scnt_q == SAMP_LAST) begin
                    samp_q <= '0;
                    if (state_q == START) begin
                        if (vote_bnd_d) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end
                    end else if (state_q == DATA) begin
                        shift_q <= {vote_bnd_d, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end

                // Mid-stop decision leaves half a bit to catch a
                // back-to-back start edge while already IDLE.
                if ((state_q == STOP) && (scnt_q == VOTE_IDX_C)) begin
                    state_q <= IDLE;
                    if (vote_mid_d) begin
                        data_q <= shift_q;
                        done_q <= 1'b1;
                    end else begin
                        ferr_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        uart_data = data_q;
        uart_done = done_q;
        frame_err = ferr_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       busy;

    uart_rx_oversample #(
        .CLK_HZ(6_400_000),
        .BAUD  (100_000),
        .OS    (16)
    ) dut (
        .sys_clk  (clk),
        .rst      (rst),
        .uart_rxd (rxd),
        .uart_data(uart_data),
        .uart_done(uart_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    localparam int BIT_CYC = 64;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Output monitor
    int          done_cnt = 0;
    int          ferr_cnt = 0;
    int          both_cnt = 0;
    int          wide_cnt = 0;
    logic        prev_done = 1'b0;
    logic        prev_ferr = 1'b0;
    logic        prev_busy = 1'b0;
    logic        done_busy = 1'b1;
    logic        done_prev_busy = 1'b0;
    logic [7:0]  dq[$];
    int unsigned cq[$];

    always @(negedge clk) begin
        if (uart_done === 1'b1) begin
            done_cnt++;
            dq.push_back(uart_data);
            cq.push_back(cyc);
            done_busy      = busy;
            done_prev_busy = prev_busy;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if ((uart_done === 1'b1) && (frame_err === 1'b1)) both_cnt++;
        if (((uart_done === 1'b1) && prev_done) || ((frame_err === 1'b1) && prev_ferr)) wide_cnt++;
        prev_done = (uart_done === 1'b1);
        prev_ferr = (frame_err === 1'b1);
        prev_busy = (busy === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, stop bit of stop_len cycles.
    // spike_bit >= 0 inverts that data bit for 4 cycles around sample 8.
    // The line is left at the stop value on return.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int spike_bit, input int stop_len);
        drive(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive(d[i], 34);
                drive(~d[i], 4);
                drive(d[i], BIT_CYC - 38);
            end else begin
                drive(d[i], BIT_CYC);
            end
        end
        drive(stop, stop_len);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         spike_bit;
        logic [7:0] exp_data;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          d0;
        int          f0;
        int          n0;
        int unsigned t0;

        vecs[0] = '{8'h3C, 1'b0, -1, 8'hA5, 0, 1};
        vecs[1] = '{8'h0F, 1'b1,  2, 8'h0F, 1, 0};
        vecs[2] = '{8'h00, 1'b1, -1, 8'h00, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, -1, 8'hFF, 1, 0};
        vecs[4] = '{8'h55, 1'b1, -1, 8'h55, 1, 0};
        vecs[5] = '{8'h3C, 1'b1,  5, 8'h3C, 1, 0};
        vecs[6] = '{8'h81, 1'b0,  0, 8'h3C, 0, 1};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset data", {24'h0, uart_data}, 32'h0);
        check("reset done", {31'h0, uart_done}, 32'h0);
        check("reset ferr", {31'h0, frame_err}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        idle(10);

        // Ideal 0xA5 frame: latency and busy/done alignment
        d0 = done_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, -1, BIT_CYC);
        idle(BIT_CYC);
        #1;
        check("a5 done count", done_cnt - d0, 1);
        check("a5 data", {24'h0, uart_data}, 32'hA5);
        check("a5 latency", (cq.size() > 0) ? cq[cq.size()-1] - t0 : 0, 619);
        check("a5 busy at done", {31'h0, done_busy}, 32'h0);
        check("a5 busy before done", {31'h0, done_prev_busy}, 32'h1);
        check("a5 no ferr", ferr_cnt, 0);

        // Table of single frames, each followed by one idle bit time
        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].spike_bit, BIT_CYC);
            idle(BIT_CYC);
            #1;
            check($sformatf("vec%0d done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("vec%0d ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d data", v), {24'h0, uart_data}, {24'h0, vecs[v].exp_data});
        end

        // Back-to-back frames with one-bit stops
        n0 = dq.size();
        send_frame(8'h00, 1'b1, -1, BIT_CYC);
        send_frame(8'hFF, 1'b1, -1, BIT_CYC);
        send_frame(8'h55, 1'b1, -1, BIT_CYC);
        idle(BIT_CYC);
        #1;
        check("b2b count", dq.size() - n0, 3);
        if (dq.size() >= n0 + 3) begin
            check("b2b data0", {24'h0, dq[n0]}, 32'h00);
            check("b2b data1", {24'h0, dq[n0+1]}, 32'hFF);
            check("b2b data2", {24'h0, dq[n0+2]}, 32'h55);
            check("b2b gap01", cq[n0+1] - cq[n0], 640);
            check("b2b gap12", cq[n0+2] - cq[n0+1], 640);
        end

        // 20-cycle glitch: false start rejected
        d0 = done_cnt;
        f0 = ferr_cnt;
        drive(1'b0, 10);
        #1;
        check("glitch busy rises", {31'h0, busy}, 32'h1);
        drive(1'b0, 10);
        idle(50);
        #1;
        check("glitch busy falls", {31'h0, busy}, 32'h0);
        check("glitch no done", done_cnt - d0, 0);
        check("glitch no ferr", ferr_cnt - f0, 0);
        idle(BIT_CYC);

        // Good byte, then bad stop with the line held low
        send_frame(8'hA5, 1'b1, -1, BIT_CYC);
        idle(BIT_CYC);
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1, 2 * BIT_CYC);
        #1;
        check("hold ferr", ferr_cnt - f0, 1);
        check("hold no done", done_cnt - d0, 0);
        check("hold data", {24'h0, uart_data}, 32'hA5);
        check("hold low idle", {31'h0, busy}, 32'h0);
        idle(BIT_CYC);
        #1;
        check("hold release idle", {31'h0, busy}, 32'h0);

        // Reset during data bit 4 of 0xC3, then 0x81
        d0 = done_cnt;
        f0 = ferr_cnt;
        begin
            logic [7:0] c3;
            c3 = 8'hC3;
            drive(1'b0, BIT_CYC);
            for (int i = 0; i < 4; i++) drive(c3[i], BIT_CYC);
            drive(c3[4], BIT_CYC / 2);
        end
        check("pre-reset busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset data", {24'h0, uart_data}, 32'h0);
        check("mid reset done", {31'h0, uart_done}, 32'h0);
        check("mid reset ferr", {31'h0, frame_err}, 32'h0);
        check("mid reset busy", {31'h0, busy}, 32'h0);
        idle(2 * BIT_CYC);
        #1;
        check("mid reset no pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
        send_frame(8'h81, 1'b1, -1, BIT_CYC);
        idle(BIT_CYC);
        #1;
        check("post reset done", done_cnt - d0, 1);
        check("post reset data", {24'h0, uart_data}, 32'h81);

        check("done/ferr overlap", both_cnt, 0);
        check("pulse width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
